imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_if.sv | 35 +++
 rtl/imem_loader.sv | 143 ++++++++++++++
 tb/tb_imem_loader.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// imem_loader_if -- byte-stream input and instruction-memory write bus
// for the program loader.
//
// Signals
//   rx_valid  upstream byte valid
//   rx_data   upstream byte
//   rx_ready  loader can accept a byte this cycle
//   im_we     instruction-memory write strobe
//   im_addr   instruction-memory word address (N bits)
//   im_wdata  instruction word to write (M bits)
//
// Modports
//   master  the loader: consumes the byte stream, drives the memory bus
//   slave   the environment: produces bytes, observes the memory bus
interface imem_loader_if #(
    parameter int N = 5,
    parameter int M = 32
);
    logic         rx_valid;
    logic [7:0]   rx_data;
    logic         rx_ready;
    logic         im_we;
    logic [N-1:0] im_addr;
    logic [M-1:0] im_wdata;

    modport master (
        input  rx_valid, rx_data,
        output rx_ready, im_we, im_addr, im_wdata
    );

    modport slave (
        output rx_valid, rx_data,
        input  rx_ready, im_we, im_addr, im_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader -- loads a program into instruction memory from a byte stream
// and holds the processor in reset until the load is verified.
//
// Stream: length byte L (1..2^N), then 4*L data bytes (big-endian words),
// then a checksum byte equal to the XOR of L and every data byte.
//
// Ports
//   CLK      system clock, rising edge
//   RST      synchronous active-high reset
//   bus      imem_loader_if.master: rx_valid/rx_data/rx_ready byte input,
//            im_we/im_addr/im_wdata memory write output
//   cpu_rst  processor reset, high until the load succeeds
//   done     program loaded and checksum verified
//   err      load failed (bad length or checksum); sticky until RST
module imem_loader #(
    parameter int N = 5,
    parameter int M = 32
) (
    input  logic          CLK,
    input  logic          RST,
    imem_loader_if.master bus,
    output logic          cpu_rst,
    output logic          done,
    output logic          err
);
    localparam logic [2:0] S_LEN  = 3'd0;
    localparam logic [2:0] S_DATA = 3'd1;
    localparam logic [2:0] S_WR   = 3'd2;
    localparam logic [2:0] S_CHK  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;
    localparam logic [2:0] S_ERR  = 3'd5;

    // The count must hold L = 2^N, so it needs one bit more than the address.
    localparam int          CW  = N + 1;
    localparam int unsigned CAP = 32'd1 << N;

    logic [2:0]    state_reg,   state_next;
    logic [CW-1:0] count_reg,   count_next;
    logic [N-1:0]  addr_reg,    addr_next;
    logic [1:0]    idx_reg,     idx_next;
    logic [M-1:0]  word_reg,    word_next;
    logic [7:0]    xor_reg,     xor_next;
    // Separate output registers so im_addr/im_wdata hold their values after
    // the write while addr_reg advances and word_reg collects the next word.
    logic [N-1:0]  wr_addr_reg, wr_addr_next;
    logic [M-1:0]  wr_data_reg, wr_data_next;

    logic rx_ready_int;
    logic accept;

    assign rx_ready_int = (state_reg == S_LEN) || (state_reg == S_DATA) ||
                          (state_reg == S_CHK);
    assign accept       = bus.rx_valid && rx_ready_int;

    always_comb begin
        state_next   = state_reg;
        count_next   = count_reg;
        addr_next    = addr_reg;
        idx_next     = idx_reg;
        word_next    = word_reg;
        xor_next     = xor_reg;
        wr_addr_next = wr_addr_reg;
        wr_data_next = wr_data_reg;

        case (state_reg)
            S_LEN: begin
                if (accept) begin
                    if ((bus.rx_data == 8'd0) || (32'(bus.rx_data) > CAP)) begin
                        state_next = S_ERR;
                    end else begin
                        count_next = CW'(bus.rx_data);
                        addr_next  = '0;
                        xor_next   = bus.rx_data;
                        idx_next   = 2'd0;
                        state_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    word_next = {word_reg[M-9:0], bus.rx_data};
                    xor_next  = xor_reg ^ bus.rx_data;
                    idx_next  = idx_reg + 2'd1;
                    // Fourth byte: latch the finished word straight into the
                    // write registers so the strobe follows one cycle later.
                    if (idx_reg == 2'd3) begin
                        wr_addr_next = addr_reg;
                        wr_data_next = {word_reg[M-9:0], bus.rx_data};
                        state_next   = S_WR;
                    end
                end
            end
            S_WR: begin
                // Increment after the final write is harmless: the address
                // is never used again once the count runs out.
                addr_next  = addr_reg + 1'b1;
                count_next = count_reg - 1'b1;
                state_next = (count_reg == CW'(1)) ? S_CHK : S_DATA;
            end
            S_CHK: begin
                if (accept) begin
                    state_next = (bus.rx_data == xor_reg) ? S_DONE : S_ERR;
                end
            end
            S_DONE, S_ERR: begin
                state_next = state_reg;
            end
            default: begin
                state_next = S_ERR;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg   <= S_LEN;
            count_reg   <= '0;
            addr_reg    <= '0;
            idx_reg     <= '0;
            word_reg    <= '0;
            xor_reg     <= '0;
            wr_addr_reg <= '0;
            wr_data_reg <= '0;
        end else begin
            state_reg   <= state_next;
            count_reg   <= count_next;
            addr_reg    <= addr_next;
            idx_reg     <= idx_next;
            word_reg    <= word_next;
            xor_reg     <= xor_next;
            wr_addr_reg <= wr_addr_next;
            wr_data_reg <= wr_data_next;
        end
    end

    assign bus.rx_ready = rx_ready_int;
    assign bus.im_we    = (state_reg == S_WR);
    assign bus.im_addr  = wr_addr_reg;
    assign bus.im_wdata = wr_data_reg;
    assign done         = (state_reg == S_DONE);
    assign err          = (state_reg == S_ERR);
    assign cpu_rst      = (state_reg != S_DONE);
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader -- scoreboard bench for imem_loader.
// Expected memory writes are queued as each word is driven and compared
// whenever the DUT raises im_we; status outputs are checked after each load.
module tb_imem_loader;
    localparam int N = 5;
    localparam int M = 32;

    typedef struct packed {
        logic [N-1:0] addr;
        logic [M-1:0] data;
    } wr_t;

    logic CLK;
    logic RST;
    logic cpu_rst;
    logic done;
    logic err;

    imem_loader_if #(.N(N), .M(M)) bus ();

    imem_loader #(.N(N), .M(M)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .bus     (bus),
        .cpu_rst (cpu_rst),
        .done    (done),
        .err     (err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int          checks = 0;
    int          errors = 0;
    wr_t         exp_q[$];
    logic [31:0] words [32];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Advance to the next falling edge and score any write the DUT makes.
    task automatic tick();
        wr_t e;
        @(negedge CLK);
        if (bus.im_we === 1'b1) begin
            $display("write addr=%0d data=%08h", bus.im_addr, bus.im_wdata);
            if (exp_q.size() == 0) begin
                check("unexpected_we", 64'(bus.im_we), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("im_addr", 64'(bus.im_addr), 64'(e.addr));
                check("im_wdata", 64'(bus.im_wdata), 64'(e.data));
            end
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        tick();
        tick();
        check("rst_rx_ready", 64'(bus.rx_ready), 64'd1);
        check("rst_im_we", 64'(bus.im_we), 64'd0);
        check("rst_im_addr", 64'(bus.im_addr), 64'd0);
        check("rst_im_wdata", 64'(bus.im_wdata), 64'd0);
        check("rst_cpu_rst", 64'(cpu_rst), 64'd1);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        RST = 1'b0;
        exp_q.delete();
    endtask

    // Offer one byte, holding it valid until the DUT is ready; returns on the
    // falling edge after the accepting rising edge.
    task automatic send_byte(input logic [7:0] b, input bit rnd);
        int n;
        if (rnd) begin
            repeat ($urandom_range(0, 2)) begin
                bus.rx_valid = 1'b0;
                bus.rx_data  = 8'($urandom);
                tick();
            end
        end
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        n = 0;
        while (bus.rx_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("ready_timeout", 64'(bus.rx_ready), 64'd1);
        tick();
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_word(input int a, input logic [31:0] w, input bit rnd);
        wr_t e;
        e.addr = N'(a);
        e.data = w;
        exp_q.push_back(e);
        send_byte(w[31:24], rnd);
        send_byte(w[23:16], rnd);
        send_byte(w[15:8], rnd);
        send_byte(w[7:0], rnd);
        check("we_latency", 64'(bus.im_we), 64'd1);
    endtask

    // Full stream from words[0..L-1]; chk_flip corrupts the checksum byte.
    task automatic run_load(input int L, input logic [7:0] chk_flip, input bit rnd);
        logic [7:0] x;
        x = 8'(L);
        send_byte(8'(L), rnd);
        for (int i = 0; i < L; i++) begin
            x = x ^ words[i][31:24] ^ words[i][23:16] ^ words[i][15:8] ^ words[i][7:0];
            send_word(i, words[i], rnd);
        end
        send_byte(x ^ chk_flip, rnd);
    endtask

    task automatic check_end(input string tag, input bit ok);
        check({tag, "_done"}, 64'(done), 64'(ok));
        check({tag, "_err"}, 64'(err), 64'(!ok));
        check({tag, "_cpu_rst"}, 64'(cpu_rst), 64'(!ok));
        check({tag, "_rx_ready"}, 64'(bus.rx_ready), 64'd0);
        repeat (3) tick();
        check({tag, "_hold"}, 64'({done, err}), 64'({ok, !ok}));
        check({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        RST = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;

        // Single-word load with correct checksum 2C.
        do_reset();
        words[0] = 32'h2008_0005;
        run_load(1, 8'h00, 1'b0);
        check_end("one_word", 1'b1);

        // Zero length is rejected immediately.
        do_reset();
        send_byte(8'h00, 1'b0);
        check("len0_err", 64'(err), 64'd1);
        check("len0_cpu_rst", 64'(cpu_rst), 64'd1);
        check_end("len0", 1'b0);

        // One past capacity is rejected.
        do_reset();
        send_byte(8'h21, 1'b0);
        check_end("len21", 1'b0);

        // Full capacity: 32 words to addresses 0..31.
        do_reset();
        for (int i = 0; i < 32; i++) words[i] = $urandom;
        run_load(32, 8'h00, 1'b0);
        check_end("full", 1'b1);

        // Bad checksum 2D: the word stays written, then error.
        do_reset();
        words[0] = 32'h2008_0005;
        run_load(1, 8'h01, 1'b0);
        check_end("bad_chk", 1'b0);

        // Random valid gaps and bytes held through the write cycle.
        do_reset();
        words[0] = 32'h2008_0005;
        run_load(1, 8'h00, 1'b1);
        check_end("gaps", 1'b1);
        do_reset();
        for (int i = 0; i < 6; i++) words[i] = $urandom;
        run_load(6, 8'h00, 1'b1);
        check_end("gaps_multi", 1'b1);

        // Reset mid-load discards the partial word and restarts at address 0.
        do_reset();
        send_byte(8'h02, 1'b0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        do_reset();
        words[0] = 32'h2008_0005;
        run_load(1, 8'h00, 1'b0);
        check_end("mid_rst", 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
